l1_miss_controller: RTL
=======================

Name: l1_miss_controller

Overview:
Sequencing controller in front of the Data_L1 data cache. It accepts single-word CPU read/write requests over a req/done handshake, drives the L1 read and write ports, and detects hit or miss. On a read miss it refills the whole block from next-level memory word by word, then replays the read. Writes are write-through with no-write-allocate. The block also keeps saturating hit and miss counters.

Parameters:
ADDR_W, 16, address width (matches Data_L1)
DATA_W, 16, data width
WORDS_PER_BLOCK, 4, words per cache block; power of 2, at least 2
CNT_W, 16, width of the statistics counters

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  request valid; sampled only while cpu_ready=1
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  controller idle, can accept a request
cpu_done  out  1  one-cycle pulse when the request completes
cpu_rdata  out  DATA_W  read data; valid when cpu_done=1 for a read, held until the next done
l1_raddr  out  ADDR_W  Data_L1 read address
l1_read  out  1  Data_L1 read enable
l1_rdata  in  DATA_W  Data_L1 read value
l1_rhit  in  1  Data_L1 read hit
l1_waddr  out  ADDR_W  Data_L1 write address
l1_wdata  out  DATA_W  Data_L1 write value
l1_write  out  1  Data_L1 write enable
l1_whit  in  1  Data_L1 write hit (informational only)
mem_req  out  1  memory request; held high until mem_ack
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data; valid with mem_ack
mem_ack  in  1  one-cycle memory completion; any latency of 1 or more cycles
hit_count  out  CNT_W  read hits, saturating
miss_count  out  CNT_W  read misses, saturating

Behaviour:
- Reset:
  - state=IDLE, cpu_ready=1.
  - cpu_done, l1_read, l1_write, mem_req and mem_we are 0.
  - All address and data outputs are 0.
  - Both counters are 0.
  - An asserted reset aborts any refill or memory access immediately.
  - A partially refilled block is not marked done. Hit/miss state after reset is Data_L1's responsibility.
- Request capture:
  - In IDLE with cpu_req=1, latch we, addr and wdata, drop cpu_ready next cycle, and go to LOOKUP (read) or WR_L1 (write).
  - Inputs are ignored while cpu_ready=0.
- Read path:
  - LOOKUP: l1_read=1 and l1_raddr=latched addr for one cycle.
  - CHECK: sample l1_rhit/l1_rdata.
  - Hit: cpu_rdata<=l1_rdata, cpu_done pulse, hit_count+1, go to IDLE. Read-hit latency is 3 cycles from request acceptance to done.
  - Miss: miss_count+1, word index<=0, go to REFILL_REQ.
- Refill:
  - REFILL_REQ holds mem_req=1, mem_we=0, mem_addr={block base, idx}. Block base = addr with the low log2(WORDS_PER_BLOCK) bits cleared.
  - On mem_ack, go to REFILL_WR: l1_write=1 for one cycle with l1_waddr={base, idx} and l1_wdata=captured mem_rdata.
  - Increment idx. When idx reaches WORDS_PER_BLOCK-1 after its write, go to LOOKUP (replay).
  - Otherwise return to REFILL_REQ.
  - The replay must hit. If the replay misses, the controller still completes with l1_rdata and does not loop. The second miss is not counted.
- Write path:
  - WR_L1: l1_write=1 for one cycle (Data_L1 updates only on a hit; no allocate).
  - WR_MEM: mem_req=1, mem_we=1 with latched addr and wdata until mem_ack.
  - Then cpu_done pulse and return to IDLE.
  - Writes do not touch the counters.
- Handshakes:
  - mem_req deasserts the cycle after mem_ack.
  - mem_ack while mem_req=0 is ignored.
  - Only one outstanding memory access at any time.
- Counters saturate at all-ones and do not wrap.
- Address wrap: a block at the top of the address space (e.g. 0xFFFC–0xFFFF) refills without carry into other blocks. The index field alone increments.
- cpu_done and cpu_ready=1 are asserted in the same cycle (back-to-back capable).

Decomposition:
- Shared package cache_pkg:
  - state enumeration: IDLE, LOOKUP, CHECK, REFILL_REQ, REFILL_WR, WR_L1, WR_MEM
  - ADDR_W/DATA_W defaults
  - OFFSET_W = log2(WORDS_PER_BLOCK)
- One sub-module: sat_counter, parameterised CNT_W with inc and reset inputs, instantiated twice.

Test Plan:
- Reset mid-refill: assert reset during REFILL_REQ -> all outputs return to reset values and cpu_ready=1; a new read completes normally.
- Cold read: read addr 0 on an empty L1, memory returns 100+addr with 2-cycle ack latency -> 4 memory reads at 0..3 and 4 L1 writes; cpu_rdata=100; miss_count=1, hit_count=0.
- Subsequent read hits: read addr 1 then addr 2 -> 3-cycle latency each, no mem_req, rdata 101 then 102; hit_count=2.
- Write-through: write 42 to addr 1 (hit), then read addr 1 -> mem write at 1 with data 42; readback 42 with no miss.
- No-allocate write: write 62 to addr 8 (miss), then read addr 8 -> memory updated; the read misses and refills block 8..11; miss_count increments.
- Top-of-address wrap and saturation: read 0xFFFE -> refill addresses 0xFFFC..0xFFFF exactly. Force hit_count to all-ones, then issue a hit -> count stays 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 miss controller slice.
// Contents:
//   DEF_*       default widths/geometry used by the interface and the controller
//   OFFSET_W    word-offset width inside a block for the default geometry
//   ctrlState_t controller state enumeration
package cache_pkg;

    localparam int DEF_ADDR_W          = 16;
    localparam int DEF_DATA_W          = 16;
    localparam int DEF_CNT_W           = 16;
    localparam int OFFSET_W            = 2;
    localparam int DEF_WORDS_PER_BLOCK = 1 << OFFSET_W;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        CHECK      = 3'd2,
        REFILL_REQ = 3'd3,
        REFILL_WR  = 3'd4,
        WR_L1      = 3'd5,
        WR_MEM     = 3'd6
    } ctrlState_t;

endpackage

// File: rtl/l1_miss_controller_if.sv
// Bus bundle between the miss controller and its environment.
// Groups:
//   cpu_*      single-word request/done handshake from the CPU side
//   l1_*       Data_L1 read and write ports
//   mem_*      next-level memory request/ack port
//   hit_count / miss_count  statistics
// Modports:
//   master  controller side (drives cpu responses, L1 and memory requests)
//   slave   environment side (CPU, Data_L1 and memory)
interface l1_miss_controller_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_done;
    logic [DATA_W-1:0] cpu_rdata;

    logic [ADDR_W-1:0] l1_raddr;
    logic              l1_read;
    logic [DATA_W-1:0] l1_rdata;
    logic              l1_rhit;
    logic [ADDR_W-1:0] l1_waddr;
    logic [DATA_W-1:0] l1_wdata;
    logic              l1_write;
    logic              l1_whit;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_done, cpu_rdata,
        output l1_raddr, l1_read, l1_waddr, l1_wdata, l1_write,
        input  l1_rdata, l1_rhit, l1_whit,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_done, cpu_rdata,
        input  l1_raddr, l1_read, l1_waddr, l1_wdata, l1_write,
        output l1_rdata, l1_rhit, l1_whit,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  hit_count, miss_count
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hit/miss statistics.
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset (clears the count)
//   inc    add one this cycle unless already all-ones
//   count  registered count value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] countReg;

    // Count register: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countReg <= {CNT_W{1'b0}};
        end else if (inc && (countReg != {CNT_W{1'b1}})) begin
            countReg <= countReg + CNT_W'(1);
        end else begin
            countReg <= countReg;
        end
    end

    assign count = countReg;

endmodule

// File: rtl/l1_miss_controller.sv
// Sequencing controller in front of Data_L1.
// Accepts one CPU read/write at a time, looks it up in Data_L1, refills a
// whole block from next-level memory on a read miss and then replays the
// read. Writes go to Data_L1 (which only updates on a hit) and always
// through to memory. Read hits/misses are counted with saturating counters.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset; aborts any refill or memory access
//   bus    l1_miss_controller_if.master (cpu_*, l1_*, mem_*, hit/miss counts)
// All bus outputs are registered.
module l1_miss_controller
    import cache_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    l1_miss_controller_if.master bus
);

    localparam int                 offsetW = $clog2(WORDS_PER_BLOCK);
    localparam logic [offsetW-1:0] lastIdx = offsetW'(WORDS_PER_BLOCK - 1);

    ctrlState_t        state,      nextState;
    logic [ADDR_W-1:0] addrReg,    nAddr;
    logic [DATA_W-1:0] wdataReg,   nWdata;
    logic [offsetW-1:0] idxReg,    nIdx;
    logic              replayReg,  nReplay;

    logic              readyReg,   nReady;
    logic              doneReg,    nDone;
    logic [DATA_W-1:0] rdataReg,   nRdata;
    logic              l1ReadReg,  nL1Read;
    logic [ADDR_W-1:0] l1RaddrReg, nL1Raddr;
    logic              l1WriteReg, nL1Write;
    logic [ADDR_W-1:0] l1WaddrReg, nL1Waddr;
    logic [DATA_W-1:0] l1WdataReg, nL1Wdata;
    logic              memReqReg,  nMemReq;
    logic              memWeReg,   nMemWe;
    logic [ADDR_W-1:0] memAddrReg, nMemAddr;
    logic [DATA_W-1:0] memWdataReg, nMemWdata;

    logic              hitInc;
    logic              missInc;
    logic [CNT_W-1:0]  hitCount;
    logic [CNT_W-1:0]  missCount;

    // Block base bits of the captured address; only the index field below
    // them moves during a refill, so the top block never carries out.
    logic [ADDR_W-offsetW-1:0] blockTag;
    assign blockTag = addrReg[ADDR_W-1:offsetW];

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            addrReg     <= {ADDR_W{1'b0}};
            wdataReg    <= {DATA_W{1'b0}};
            idxReg      <= {offsetW{1'b0}};
            replayReg   <= 1'b0;
            readyReg    <= 1'b1;
            doneReg     <= 1'b0;
            rdataReg    <= {DATA_W{1'b0}};
            l1ReadReg   <= 1'b0;
            l1RaddrReg  <= {ADDR_W{1'b0}};
            l1WriteReg  <= 1'b0;
            l1WaddrReg  <= {ADDR_W{1'b0}};
            l1WdataReg  <= {DATA_W{1'b0}};
            memReqReg   <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= {ADDR_W{1'b0}};
            memWdataReg <= {DATA_W{1'b0}};
        end else begin
            state       <= nextState;
            addrReg     <= nAddr;
            wdataReg    <= nWdata;
            idxReg      <= nIdx;
            replayReg   <= nReplay;
            readyReg    <= nReady;
            doneReg     <= nDone;
            rdataReg    <= nRdata;
            l1ReadReg   <= nL1Read;
            l1RaddrReg  <= nL1Raddr;
            l1WriteReg  <= nL1Write;
            l1WaddrReg  <= nL1Waddr;
            l1WdataReg  <= nL1Wdata;
            memReqReg   <= nMemReq;
            memWeReg    <= nMemWe;
            memAddrReg  <= nMemAddr;
            memWdataReg <= nMemWdata;
        end
    end

    // Next state plus the next value of every registered output. Outputs are
    // computed for the state being entered so they are valid in that state.
    always_comb begin
        nextState = state;
        nAddr     = addrReg;
        nWdata    = wdataReg;
        nIdx      = idxReg;
        nReplay   = replayReg;
        nReady    = readyReg;
        nDone     = 1'b0;
        nRdata    = rdataReg;
        nL1Read   = 1'b0;
        nL1Raddr  = l1RaddrReg;
        nL1Write  = 1'b0;
        nL1Waddr  = l1WaddrReg;
        nL1Wdata  = l1WdataReg;
        nMemReq   = memReqReg;
        nMemWe    = memWeReg;
        nMemAddr  = memAddrReg;
        nMemWdata = memWdataReg;
        hitInc    = 1'b0;
        missInc   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    nAddr   = bus.cpu_addr;
                    nWdata  = bus.cpu_wdata;
                    nReady  = 1'b0;
                    nReplay = 1'b0;
                    if (bus.cpu_we) begin
                        nextState = WR_L1;
                        nL1Write  = 1'b1;
                        nL1Waddr  = bus.cpu_addr;
                        nL1Wdata  = bus.cpu_wdata;
                    end else begin
                        nextState = LOOKUP;
                        nL1Read   = 1'b1;
                        nL1Raddr  = bus.cpu_addr;
                    end
                end else begin
                    nextState = IDLE;
                end
            end

            LOOKUP: begin
                nextState = CHECK;
            end

            CHECK: begin
                // A replay completes regardless of hit so a misbehaving L1
                // cannot trap the controller in a refill loop.
                if (bus.l1_rhit || replayReg) begin
                    nextState = IDLE;
                    nDone     = 1'b1;
                    nReady    = 1'b1;
                    nRdata    = bus.l1_rdata;
                    hitInc    = bus.l1_rhit & ~replayReg;
                end else begin
                    missInc   = 1'b1;
                    nIdx      = {offsetW{1'b0}};
                    nextState = REFILL_REQ;
                    nMemReq   = 1'b1;
                    nMemWe    = 1'b0;
                    nMemAddr  = {blockTag, {offsetW{1'b0}}};
                end
            end

            REFILL_REQ: begin
                if (bus.mem_ack) begin
                    nMemReq   = 1'b0;
                    nextState = REFILL_WR;
                    nL1Write  = 1'b1;
                    nL1Waddr  = {blockTag, idxReg};
                    nL1Wdata  = bus.mem_rdata;
                end else begin
                    nextState = REFILL_REQ;
                end
            end

            REFILL_WR: begin
                if (idxReg == lastIdx) begin
                    nIdx      = {offsetW{1'b0}};
                    nReplay   = 1'b1;
                    nextState = LOOKUP;
                    nL1Read   = 1'b1;
                    nL1Raddr  = addrReg;
                end else begin
                    nIdx      = idxReg + offsetW'(1);
                    nextState = REFILL_REQ;
                    nMemReq   = 1'b1;
                    nMemWe    = 1'b0;
                    nMemAddr  = {blockTag, idxReg + offsetW'(1)};
                end
            end

            WR_L1: begin
                nextState = WR_MEM;
                nMemReq   = 1'b1;
                nMemWe    = 1'b1;
                nMemAddr  = addrReg;
                nMemWdata = wdataReg;
            end

            WR_MEM: begin
                if (bus.mem_ack) begin
                    nMemReq   = 1'b0;
                    nMemWe    = 1'b0;
                    nDone     = 1'b1;
                    nReady    = 1'b1;
                    nextState = IDLE;
                end else begin
                    nextState = WR_MEM;
                end
            end

            default: begin
                nextState = IDLE;
                nReady    = 1'b1;
                nMemReq   = 1'b0;
                nMemWe    = 1'b0;
            end
        endcase
    end

    sat_counter #(.CNT_W(CNT_W)) u_hitCounter (
        .clk   (clk),
        .rst   (reset),
        .inc   (hitInc),
        .count (hitCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_missCounter (
        .clk   (clk),
        .rst   (reset),
        .inc   (missInc),
        .count (missCount)
    );

    assign bus.cpu_ready  = readyReg;
    assign bus.cpu_done   = doneReg;
    assign bus.cpu_rdata  = rdataReg;
    assign bus.l1_read    = l1ReadReg;
    assign bus.l1_raddr   = l1RaddrReg;
    assign bus.l1_write   = l1WriteReg;
    assign bus.l1_waddr   = l1WaddrReg;
    assign bus.l1_wdata   = l1WdataReg;
    assign bus.mem_req    = memReqReg;
    assign bus.mem_we     = memWeReg;
    assign bus.mem_addr   = memAddrReg;
    assign bus.mem_wdata  = memWdataReg;
    assign bus.hit_count  = hitCount;
    assign bus.miss_count = missCount;

endmodule
